// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: memory-mapped 7-segment display controller on the picorv32
// native memory bus. Firmware writes the digit nibbles (VALUE) and the blank
// mask plus blink enable (CTRL). It can read back a count of accepted writes
// (WCOUNT).
// Optional feature macro: HEX_DISPLAY_BLINK_EN adds a free-running blink
// prescaler and makes CTRL[8] a working blink enable.
module hex_display_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
    parameter int          NUM_DIGITS  = 4,
    parameter int          BLINK_DIV_W = 24
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    mem_valid,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    output logic                    mem_ready,
    output logic [31:0]             mem_rdata,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   blank
);

    localparam int VW = 4 * NUM_DIGITS;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // gap_q is set in the IDLE cycle that directly follows an ACK. A request
    // is not taken in that cycle, so a master that keeps mem_valid high sees
    // at least one idle cycle between two acknowledges.
    logic gap_q;

    logic          sel;
    logic          accept;
    logic          is_write;
    logic [1:0]    offset;

    logic [VW-1:0]         value_q, value_d, value_wr;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [15:0]           wcount_q, wcount_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           rd_word;
    logic                  blink_en_rd;
    logic                  blink_dark;

    // Address bits below word granularity are not decoded. Write-data bits
    // beyond the implemented fields are dropped.
    logic unused_bits;
    assign unused_bits = ^{mem_addr[1:0], mem_wdata};

    assign sel      = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign accept   = (state_q == IDLE) && !gap_q && sel;
    assign is_write = |mem_wstrb;
    assign offset   = mem_addr[3:2];

    // Each VALUE bit follows the strobe of the byte lane that carries it.
    for (genvar gi = 0; gi < VW; gi++) begin : g_value_lane
        assign value_wr[gi] = mem_wstrb[gi / 8] ? mem_wdata[gi] : value_q[gi];
    end

`ifdef HEX_DISPLAY_BLINK_EN
    logic                   blink_en_q, blink_en_d;
    logic [BLINK_DIV_W-1:0] presc_q, presc_d;
    logic                   blink_start;

    // This is a 0->1 write of the blink enable. It restarts the blink phase,
    // so the display comes up lit.
    assign blink_start = accept && is_write && (offset == 2'd1) && mem_wstrb[1]
                         && mem_wdata[8] && !blink_en_q;

    // Next state of the prescaler: free-running, restarted on blink enable.
    always_comb begin
        presc_d = presc_q + 1'b1;
        if (blink_start) begin
            presc_d = '0;
        end
    end

    // Prescaler and blink-enable registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q    <= '0;
            blink_en_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            blink_en_q <= blink_en_d;
        end
    end

    // Next state of the blink enable. It is only writable through byte lane 1.
    always_comb begin
        blink_en_d = blink_en_q;
        if (accept && is_write && (offset == 2'd1) && mem_wstrb[1]) begin
            blink_en_d = mem_wdata[8];
        end
    end

    assign blink_en_rd = blink_en_q;
    assign blink_dark  = blink_en_q & presc_q[BLINK_DIV_W-1];
`else
    assign blink_en_rd = 1'b0;
    assign blink_dark  = 1'b0;
`endif

    // Read mux over the register window. Unimplemented bits read as zero.
    always_comb begin
        rd_word = '0;
        case (offset)
            2'd0: rd_word[VW-1:0] = value_q;
            2'd1: begin
                rd_word[NUM_DIGITS-1:0] = mask_q;
                rd_word[8]              = blink_en_rd;
            end
            2'd2: rd_word[15:0] = wcount_q;
            default: rd_word = '0;
        endcase
    end

    // Bus FSM next state: each accepted request is acknowledged for one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = ACK;
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus FSM state register and the gap flag after each acknowledge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            gap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= (state_q == ACK);
        end
    end

    // Register-file next state. A write commits on the same edge that enters
    // ACK, so the new value is already on the outputs during the acknowledge.
    always_comb begin
        value_d  = value_q;
        mask_d   = mask_q;
        wcount_d = wcount_q;
        rdata_d  = '0;
        if (accept) begin
            if (is_write) begin
                wcount_d = wcount_q + 16'd1;
                case (offset)
                    2'd0: value_d = value_wr;
                    2'd1: if (mem_wstrb[0]) mask_d = mem_wdata[NUM_DIGITS-1:0];
                    default: ;
                endcase
            end else begin
                rdata_d = rd_word;
            end
        end
    end

    // Register file and the read-data holding register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            value_q  <= '0;
            mask_q   <= '0;
            wcount_q <= '0;
            rdata_q  <= '0;
        end else begin
            value_q  <= value_d;
            mask_q   <= mask_d;
            wcount_q <= wcount_d;
            rdata_q  <= rdata_d;
        end
    end

    assign mem_ready = (state_q == ACK);
    assign mem_rdata = rdata_q;
    assign digits    = value_q;
    assign blank     = mask_q | {NUM_DIGITS{blink_dark}};

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: directed and randomized bus traffic against
// hex_display_ctrl. A behavioural model of the register window predicts the
// read data, digits and blank for each transaction.
module tb_hex_display_ctrl;

    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [15:0] digits;
    logic [3:0]  blank;

    int checks   = 0;
    int failures = 0;

    // Model of the register window.
    logic [15:0] m_value;
    logic [3:0]  m_mask;
    logic        m_blink;
    logic [15:0] m_wcount;

    hex_display_ctrl #(
        .BASE_ADDR  (BASE),
        .NUM_DIGITS (4),
        .BLINK_DIV_W(4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .mem_valid(mem_valid),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .digits   (digits),
        .blank    (blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_value  = '0;
        m_mask   = '0;
        m_blink  = 1'b0;
        m_wcount = '0;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] off);
        case (off)
            2'd0:    return {16'h0, m_value};
            2'd1:    return {23'h0, m_blink, 4'h0, m_mask};
            2'd2:    return {16'h0, m_wcount};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_write(input logic [1:0] off, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] v;
        v = {16'h0, m_value};
        case (off)
            2'd0: begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) v[8*b +: 8] = wd[8*b +: 8];
                m_value = v[15:0];
            end
            2'd1: begin
                if (ws[0]) m_mask = wd[3:0];
`ifdef HEX_DISPLAY_BLINK_EN
                if (ws[1]) m_blink = wd[8];
`endif
            end
            default: ;
        endcase
        m_wcount = m_wcount + 16'd1;
    endtask

    // One bus transaction from an idle bus. It checks the latency and the read
    // data, and also the display outputs in the ACK cycle.
    task automatic xact(input string tag, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] ws,
                        output logic [31:0] rd);
        int          lat;
        logic [31:0] exp_rd;
        repeat (2) @(posedge clk);
        #1;
        exp_rd    = (ws == 4'h0) ? model_read(addr[3:2]) : 32'h0;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wd;
        mem_wstrb = ws;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!mem_ready && lat < 8);
        rd        = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        if (ws != 4'h0) model_write(addr[3:2], wd, ws);
        $display("xact %s addr=%h wdata=%h wstrb=%b rdata=%h lat=%0d", tag, addr, wd, ws, rd, lat);
        chk({tag, "_lat"}, lat, 32'd1);
        chk({tag, "_rdata"}, rd, exp_rd);
        chk({tag, "_digits"}, {16'h0, digits}, {16'h0, m_value});
        chk({tag, "_blank"}, {28'h0, blank}, {28'h0, m_mask});
    endtask

    initial begin
        logic [31:0] rd;
        logic [5:0]  rdy_seen;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic [1:0]  off;
        logic        seen;

        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Outputs immediately after reset
        chk("rst_ready", {31'h0, mem_ready}, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_digits", {16'h0, digits}, 32'h0);
        chk("rst_blank", {28'h0, blank}, 32'h0);
        xact("rd_value0", BASE + 32'h0, 32'h0, 4'h0, rd);
        chk("rst_value", rd, 32'h0);
        xact("rd_ctrl0", BASE + 32'h4, 32'h0, 4'h0, rd);
        chk("rst_ctrl", rd, 32'h0);
        xact("rd_wcnt0", BASE + 32'h8, 32'h0, 4'h0, rd);
        chk("rst_wcount", rd, 32'h0);

        // Directed register accesses
        xact("wr_beef", BASE + 32'h0, 32'h0000_BEEF, 4'hF, rd);
        chk("beef_digits", {16'h0, digits}, 32'h0000_BEEF);
        xact("rd_wcnt1", BASE + 32'h8, 32'h0, 4'h0, rd);
        chk("wcount_1", rd, 32'h1);
        xact("wr_lane1", BASE + 32'h0, 32'h0000_1200, 4'b0010, rd);
        chk("lane1_digits", {16'h0, digits}, 32'h0000_12EF);
        xact("wr_ctrl5", BASE + 32'h4, 32'h5, 4'hF, rd);
        chk("ctrl5_blank", {28'h0, blank}, 32'h5);
        xact("rd_ctrl5", BASE + 32'h4, 32'h0, 4'h0, rd);
        chk("ctrl5_read", rd, 32'h0000_0005);
        xact("wr_hole", BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, rd);
        xact("rd_hole", BASE + 32'hC, 32'h0, 4'h0, rd);
        chk("hole_read", rd, 32'h0);

        // mem_valid held for 6 cycles on a read: acknowledges only in cycles 1 and 4
        repeat (2) @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_addr  = BASE;
        mem_wstrb = 4'h0;
        rdy_seen  = '0;
        rdy_seen[0] = mem_ready;
        for (int i = 1; i < 6; i++) begin
            @(posedge clk);
            #1;
            rdy_seen[i] = mem_ready;
        end
        mem_valid = 1'b0;
        $display("xact hold_read ready_pattern=%b", rdy_seen);
        chk("hold_ready_pattern", {26'h0, rdy_seen}, 32'h0000_0012);

        // Out-of-window write: no acknowledge and no state change
        repeat (2) @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_addr  = 32'h0300_0010;
        mem_wdata = 32'hFFFF_FFFF;
        mem_wstrb = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            seen = seen | mem_ready;
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        $display("xact out_of_window addr=%h ready_seen=%b", 32'h0300_0010, seen);
        chk("oow_no_ack", {31'h0, seen}, 32'h0);
        chk("oow_digits", {16'h0, digits}, {16'h0, m_value});
        xact("oow_wcnt", BASE + 32'h8, 32'h0, 4'h0, rd);

        // Blink behaviour
`ifdef HEX_DISPLAY_BLINK_EN
        xact("blink_on", BASE + 32'h4, 32'h100, 4'hF, rd);
        for (int k = 0; k < 24; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("blink_k%0d", k), {28'h0, blank},
                ((k % 16) < 8) ? 32'h0 : 32'hF);
        end
        xact("blink_rd", BASE + 32'h4, 32'h0, 4'h0, rd);
        chk("blink_ctrl_read", rd, 32'h100);
        xact("blink_off", BASE + 32'h4, 32'h0, 4'hF, rd);
`else
        xact("blink_on", BASE + 32'h4, 32'h100, 4'hF, rd);
        xact("blink_rd", BASE + 32'h4, 32'h0, 4'h0, rd);
        chk("noblink_ctrl_read", rd, 32'h0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            seen = |blank;
            if (k == 19) chk("noblink_blank", {28'h0, blank}, 32'h0);
        end
`endif

        // Randomized traffic. Blink stays off in this phase so that blank
        // follows the mask alone.
        for (int n = 0; n < 60; n++) begin
            off = 2'($urandom_range(0, 3));
            wd  = $urandom;
            ws  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if (off == 2'd1) wd[8] = 1'b0;
            xact($sformatf("rnd%0d", n), BASE + {28'h0, off, 2'b00}, wd, ws, rd);
        end
        xact("rnd_wcnt", BASE + 32'h8, 32'h0, 4'h0, rd);

        // Reset asserted in the ACK cycle of a write
        repeat (2) @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_addr  = BASE;
        mem_wdata = 32'h0000_FFFF;
        mem_wstrb = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = mem_ready;
        end
        chk("rstack_got_ack", {31'h0, seen}, 32'h1);
        resetn    = 1'b0;
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
        model_reset();
        $display("xact reset_in_ack ready=%b digits=%h", mem_ready, digits);
        chk("rstack_ready", {31'h0, mem_ready}, 32'h0);
        chk("rstack_digits", {16'h0, digits}, 32'h0);
        resetn = 1'b1;
        xact("rstack_wcnt", BASE + 32'h8, 32'h0, 4'h0, rd);
        chk("rstack_wcount", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
